// File: rtl/char_buf_pkg.sv
// Shared types for the character-buffer RAM scheduler: screen geometry, cell
// layout, queued write command and scheduler state.
package char_buf_pkg;

  localparam int DEF_H_CHARS = 80;
  localparam int DEF_V_CHARS = 60;
  localparam int CELL_W      = 12;
  localparam int HCHAR_W     = 7;
  localparam int VCHAR_W     = 6;

  // ASCII code sits in the low byte so a plain character value is also a valid cell
  typedef struct packed {
    logic [3:0] colour;
    logic [7:0] ch;
  } cell_t;

  typedef struct packed {
    logic [HCHAR_W-1:0] hchar;
    logic [VCHAR_W-1:0] vchar;
    cell_t              data;
  } wr_cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sched_state_e;

endpackage

// File: rtl/char_buf_scheduler_if.sv
// Bundle of VGA read, host write, clear request and RAM port signals around the
// scheduler; slave is the scheduler side, master the surrounding system.
interface char_buf_scheduler_if
  import char_buf_pkg::*;
#(
  parameter int DATA_W = CELL_W
);

  logic               vga_rd_en;
  logic [HCHAR_W-1:0] vga_hchar;
  logic [VCHAR_W-1:0] vga_vchar;

  logic               wr_valid;
  logic               wr_ready;
  logic [HCHAR_W-1:0] wr_hchar;
  logic [VCHAR_W-1:0] wr_vchar;
  logic [DATA_W-1:0]  wr_data;

  logic               clr_req;
  logic [DATA_W-1:0]  clr_data;
  logic               clr_busy;
  logic               err_oob;

  logic               ram_en;
  logic               ram_we;
  logic [HCHAR_W-1:0] ram_hchar;
  logic [VCHAR_W-1:0] ram_vchar;
  logic [DATA_W-1:0]  ram_wdata;

  modport slave (
    input  vga_rd_en, vga_hchar, vga_vchar,
    input  wr_valid, wr_hchar, wr_vchar, wr_data,
    input  clr_req, clr_data,
    output wr_ready, clr_busy, err_oob,
    output ram_en, ram_we, ram_hchar, ram_vchar, ram_wdata
  );

  modport master (
    output vga_rd_en, vga_hchar, vga_vchar,
    output wr_valid, wr_hchar, wr_vchar, wr_data,
    output clr_req, clr_data,
    input  wr_ready, clr_busy, err_oob,
    input  ram_en, ram_we, ram_hchar, ram_vchar, ram_wdata
  );

endinterface

// File: rtl/char_cmd_fifo.sv
// Synchronous FIFO of host write commands. Flush discards everything already
// queued but still keeps a push made in the same cycle.
module char_cmd_fifo
  import char_buf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  wr_cmd_t push_cmd,
  output wr_cmd_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wr_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Old entries vanish by moving the read pointer up to the write pointer
      rd_ptr <= wr_ptr;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count  <= {{AW{1'b0}}, push};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/char_buf_scheduler.sv
// Single-port character RAM arbiter: VGA reads always win, queued host writes
// and the clear-screen sweep use only the cycles the scan-out leaves free.
module char_buf_scheduler
  import char_buf_pkg::*;
#(
  parameter int H_CHARS    = DEF_H_CHARS,
  parameter int V_CHARS    = DEF_V_CHARS,
  parameter int DATA_W     = CELL_W,
  parameter int FIFO_DEPTH = 8
) (
  input logic                 clk_25M,
  input logic                 rst_n,
  char_buf_scheduler_if.slave bus
);

  sched_state_e       state;
  sched_state_e       state_next;
  logic [HCHAR_W-1:0] clr_h;
  logic [VCHAR_W-1:0] clr_v;
  logic [DATA_W-1:0]  clr_fill;
  logic               err_q;

  logic    fifo_push;
  logic    fifo_pop;
  logic    fifo_flush;
  logic    fifo_full;
  logic    fifo_empty;
  wr_cmd_t fifo_head;
  wr_cmd_t push_cmd;

  logic push_ok;
  logic out_of_range;
  logic free_cycle;
  logic sweep_wr;
  logic sweep_last;

  assign free_cycle   = !bus.vga_rd_en;
  assign push_ok      = bus.wr_valid && bus.wr_ready;
  assign out_of_range = (bus.wr_hchar >= HCHAR_W'(H_CHARS)) || (bus.wr_vchar >= VCHAR_W'(V_CHARS));
  assign fifo_push    = push_ok && !out_of_range;
  assign fifo_flush   = (state == IDLE) && bus.clr_req;
  assign fifo_pop     = (state == IDLE) && !bus.clr_req && free_cycle && !fifo_empty;
  assign sweep_wr     = (state == CLEAR) && free_cycle;
  assign sweep_last   = sweep_wr && (clr_h == HCHAR_W'(H_CHARS - 1)) && (clr_v == VCHAR_W'(V_CHARS - 1));

  assign push_cmd = '{hchar: bus.wr_hchar, vchar: bus.wr_vchar, data: cell_t'(bus.wr_data)};

  char_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_25M),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .push_cmd (push_cmd),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.clr_req) state_next = CLEAR;
      CLEAR: if (sweep_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sweep position and fill value; the fill is captured once so later clr_data changes are ignored
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      clr_h    <= '0;
      clr_v    <= '0;
      clr_fill <= '0;
    end else if (fifo_flush) begin
      clr_h    <= '0;
      clr_v    <= '0;
      clr_fill <= bus.clr_data;
    end else if (sweep_wr) begin
      if (clr_h == HCHAR_W'(H_CHARS - 1)) begin
        clr_h <= '0;
        clr_v <= sweep_last ? '0 : clr_v + VCHAR_W'(1);
      end else begin
        clr_h <= clr_h + HCHAR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= push_ok && out_of_range;
  end

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_hchar = '0;
    bus.ram_vchar = '0;
    bus.ram_wdata = '0;
    if (bus.vga_rd_en) begin
      bus.ram_en    = 1'b1;
      bus.ram_hchar = bus.vga_hchar;
      bus.ram_vchar = bus.vga_vchar;
    end else if (fifo_pop) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_hchar = fifo_head.hchar;
      bus.ram_vchar = fifo_head.vchar;
      bus.ram_wdata = fifo_head.data;
    end else if (sweep_wr) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_hchar = clr_h;
      bus.ram_vchar = clr_v;
      bus.ram_wdata = clr_fill;
    end
  end

  assign bus.wr_ready = !fifo_full;
  assign bus.clr_busy = (state == CLEAR);
  assign bus.err_oob  = err_q;

endmodule

// File: tb/tb_char_buf_scheduler.sv
// Directed bench for char_buf_scheduler: a vector table for single-cycle
// behaviour plus hand sequences for queue fill, clear sweeps and reset.
module tb_char_buf_scheduler;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  char_buf_scheduler_if #(.DATA_W(12)) bus ();

  char_buf_scheduler #(
    .H_CHARS    (80),
    .V_CHARS    (60),
    .DATA_W     (12),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_25M (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vga;
    logic [6:0]  vga_h;
    logic [5:0]  vga_v;
    logic        wr;
    logic [6:0]  wr_h;
    logic [5:0]  wr_v;
    logic [11:0] wr_d;
    logic        exp_en;
    logic        exp_we;
    logic [6:0]  exp_h;
    logic [5:0]  exp_v;
    logic [11:0] exp_wd;
    logic        exp_rdy;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveCycle(input logic vga, input logic [6:0] vh, input logic [5:0] vv,
                            input logic wr, input logic [6:0] wh, input logic [5:0] wv,
                            input logic [11:0] wd, input logic clr, input logic [11:0] cd);
    @(negedge clk);
    bus.vga_rd_en = vga;
    bus.vga_hchar = vh;
    bus.vga_vchar = vv;
    bus.wr_valid  = wr;
    bus.wr_hchar  = wh;
    bus.wr_vchar  = wv;
    bus.wr_data   = wd;
    bus.clr_req   = clr;
    bus.clr_data  = cd;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveCycle(v.vga, v.vga_h, v.vga_v, v.wr, v.wr_h, v.wr_v, v.wr_d, 1'b0, 12'h000);
    checkOutput({v.name, ".ram_en"},    32'(bus.ram_en),    32'(v.exp_en));
    checkOutput({v.name, ".ram_we"},    32'(bus.ram_we),    32'(v.exp_we));
    checkOutput({v.name, ".ram_hchar"}, 32'(bus.ram_hchar), 32'(v.exp_h));
    checkOutput({v.name, ".ram_vchar"}, 32'(bus.ram_vchar), 32'(v.exp_v));
    checkOutput({v.name, ".ram_wdata"}, 32'(bus.ram_wdata), 32'(v.exp_wd));
    checkOutput({v.name, ".wr_ready"},  32'(bus.wr_ready),  32'(v.exp_rdy));
    checkOutput({v.name, ".err_oob"},   32'(bus.err_oob),   32'(v.exp_err));
    checkOutput({v.name, ".clr_busy"},  32'(bus.clr_busy),  32'd0);
  endtask

  // Runs sweep cycles with vga_rd_en toggling until stop_at sweep writes are seen,
  // tallying writes that break row-major order/fill and cycles where clr_busy is low
  task automatic runSweep(input logic [11:0] fill, input int req_at, input int stop_at,
                          output int n_wr, output int n_bad, output int busy_bad);
    int h;
    int v;
    h = 0; v = 0; n_wr = 0; n_bad = 0; busy_bad = 0;
    for (int cyc = 0; cyc < 12000 && n_wr < stop_at; cyc++) begin
      driveCycle(cyc[0], 7'(cyc % 80), 6'(cyc % 60), 1'b0, 7'd0, 6'd0, 12'h000,
                 (n_wr == req_at), ~fill);
      if (!bus.clr_busy) busy_bad++;
      if (bus.vga_rd_en) begin
        if (bus.ram_we || !bus.ram_en || bus.ram_hchar != bus.vga_hchar || bus.ram_vchar != bus.vga_vchar)
          n_bad++;
      end else if (bus.ram_we) begin
        if (bus.ram_hchar != 7'(h) || bus.ram_vchar != 6'(v) || bus.ram_wdata != fill) n_bad++;
        n_wr++;
        h++;
        if (h == 80) begin
          h = 0;
          v++;
        end
      end
    end
    bus.clr_req = 1'b0;
  endtask

  initial begin
    int n_wr;
    int n_bad;
    int busy_bad;
    int stray;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{1'b0, 7'd0,  6'd0,  1'b0, 7'd0,  6'd0,  12'h000, 1'b0, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b0, "idle"};
    vecs[1]  = '{1'b0, 7'd0,  6'd0,  1'b1, 7'd5,  6'd3,  12'h041, 1'b0, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b0, "push_5_3"};
    vecs[2]  = '{1'b0, 7'd0,  6'd0,  1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b1, 7'd5,  6'd3,  12'h041, 1'b1, 1'b0, "write_5_3"};
    vecs[3]  = '{1'b1, 7'd10, 6'd20, 1'b1, 7'd7,  6'd7,  12'h123, 1'b1, 1'b0, 7'd10, 6'd20, 12'h000, 1'b1, 1'b0, "vga_read_push"};
    vecs[4]  = '{1'b1, 7'd11, 6'd20, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b0, 7'd11, 6'd20, 12'h000, 1'b1, 1'b0, "vga_read_hold"};
    vecs[5]  = '{1'b0, 7'd0,  6'd0,  1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b1, 7'd7,  6'd7,  12'h123, 1'b1, 1'b0, "write_7_7"};
    vecs[6]  = '{1'b0, 7'd0,  6'd0,  1'b1, 7'd80, 6'd0,  12'h005, 1'b0, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b0, "push_oob_h"};
    vecs[7]  = '{1'b0, 7'd0,  6'd0,  1'b1, 7'd0,  6'd60, 12'h005, 1'b0, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b1, "push_oob_v"};
    vecs[8]  = '{1'b0, 7'd0,  6'd0,  1'b0, 7'd0,  6'd0,  12'h000, 1'b0, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b1, "err_pulse_2"};
    vecs[9]  = '{1'b0, 7'd0,  6'd0,  1'b0, 7'd0,  6'd0,  12'h000, 1'b0, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b0, "oob_dropped"};
    vecs[10] = '{1'b0, 7'd0,  6'd0,  1'b1, 7'd79, 6'd59, 12'hFFF, 1'b0, 1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b0, "push_corner"};
    vecs[11] = '{1'b1, 7'd3,  6'd4,  1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b0, 7'd3,  6'd4,  12'h000, 1'b1, 1'b0, "vga_over_corner"};
    vecs[12] = '{1'b0, 7'd0,  6'd0,  1'b0, 7'd0,  6'd0,  12'h000, 1'b1, 1'b1, 7'd79, 6'd59, 12'hFFF, 1'b1, 1'b0, "write_corner"};

    rst_n = 1'b0;
    driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("reset.ram_we",    32'(bus.ram_we),    32'd0);
    checkOutput("reset.ram_wdata", 32'(bus.ram_wdata), 32'd0);
    checkOutput("reset.clr_busy",  32'(bus.clr_busy),  32'd0);
    checkOutput("reset.err_oob",   32'(bus.err_oob),   32'd0);
    checkOutput("reset.wr_ready",  32'(bus.wr_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // VGA owns the port for 20 cycles while 8 writes fill the queue
    for (int i = 0; i < 20; i++) begin
      driveCycle(1'b1, 7'(i + 20), 6'(i), (i < 8), 7'(i), 6'(i + 1), 12'(12'h100 + i), 1'b0, 12'h000);
      checkOutput($sformatf("fill%0d.ram_en", i),    32'(bus.ram_en),    32'd1);
      checkOutput($sformatf("fill%0d.ram_we", i),    32'(bus.ram_we),    32'd0);
      checkOutput($sformatf("fill%0d.ram_hchar", i), 32'(bus.ram_hchar), 32'(i + 20));
      checkOutput($sformatf("fill%0d.ram_vchar", i), 32'(bus.ram_vchar), 32'(i));
      checkOutput($sformatf("fill%0d.wr_ready", i),  32'(bus.wr_ready),  32'(i < 8));
    end
    for (int j = 0; j < 8; j++) begin
      driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
      checkOutput($sformatf("drain%0d.ram_we", j),    32'(bus.ram_we),    32'd1);
      checkOutput($sformatf("drain%0d.ram_hchar", j), 32'(bus.ram_hchar), 32'(j));
      checkOutput($sformatf("drain%0d.ram_vchar", j), 32'(bus.ram_vchar), 32'(j + 1));
      checkOutput($sformatf("drain%0d.ram_wdata", j), 32'(bus.ram_wdata), 32'(12'h100 + j));
    end
    driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("drained.ram_en", 32'(bus.ram_en), 32'd0);

    // Full clear with fill 0x020
    driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b1, 12'h020);
    checkOutput("clr_req.ram_we",   32'(bus.ram_we),   32'd0);
    checkOutput("clr_req.clr_busy", 32'(bus.clr_busy), 32'd0);
    runSweep(12'h020, -1, 4800, n_wr, n_bad, busy_bad);
    checkOutput("clear1.writes",   32'(n_wr),     32'd4800);
    checkOutput("clear1.bad",      32'(n_bad),    32'd0);
    checkOutput("clear1.busy_low", 32'(busy_bad), 32'd0);
    driveCycle(1'b1, 7'd2, 6'd2, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("clear1_end.clr_busy", 32'(bus.clr_busy), 32'd0);
    checkOutput("clear1_end.ram_we",   32'(bus.ram_we),   32'd0);
    driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("clear1_after.ram_en", 32'(bus.ram_en), 32'd0);

    // Three queued writes are flushed by clr_req; the same-cycle push survives the sweep
    for (int k = 0; k < 3; k++)
      driveCycle(1'b1, 7'd0, 6'd0, 1'b1, 7'(k + 2), 6'd2, 12'(12'h111 * (k + 1)), 1'b0, 12'h000);
    driveCycle(1'b0, 7'd0, 6'd0, 1'b1, 7'd1, 6'd1, 12'h7AA, 1'b1, 12'h031);
    checkOutput("clr_push.ram_we", 32'(bus.ram_we), 32'd0);
    runSweep(12'h031, 100, 4800, n_wr, n_bad, busy_bad);
    checkOutput("clear2.writes",   32'(n_wr),     32'd4800);
    checkOutput("clear2.bad",      32'(n_bad),    32'd0);
    checkOutput("clear2.busy_low", 32'(busy_bad), 32'd0);
    driveCycle(1'b1, 7'd9, 6'd9, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("clear2_end.clr_busy", 32'(bus.clr_busy), 32'd0);
    checkOutput("clear2_end.ram_we",   32'(bus.ram_we),   32'd0);
    driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("kept.ram_we",    32'(bus.ram_we),    32'd1);
    checkOutput("kept.ram_hchar", 32'(bus.ram_hchar), 32'd1);
    checkOutput("kept.ram_vchar", 32'(bus.ram_vchar), 32'd1);
    checkOutput("kept.ram_wdata", 32'(bus.ram_wdata), 32'h7AA);
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
      if (bus.ram_en) stray++;
    end
    checkOutput("flushed.stray_writes", 32'(stray), 32'd0);

    // Reset lands while the sweep counter sits at (10,2)
    driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b1, 12'h0AA);
    runSweep(12'h0AA, -1, 170, n_wr, n_bad, busy_bad);
    checkOutput("clear3.writes", 32'(n_wr),  32'd170);
    checkOutput("clear3.bad",    32'(n_bad), 32'd0);
    driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
    checkOutput("pre_reset.ram_we", 32'(bus.ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset.ram_we",    32'(bus.ram_we),    32'd0);
    checkOutput("mid_reset.clr_busy",  32'(bus.clr_busy),  32'd0);
    checkOutput("mid_reset.ram_wdata", 32'(bus.ram_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      driveCycle(1'b0, 7'd0, 6'd0, 1'b0, 7'd0, 6'd0, 12'h000, 1'b0, 12'h000);
      if (bus.ram_we || bus.clr_busy) stray++;
    end
    checkOutput("post_reset.stray_writes", 32'(stray),        32'd0);
    checkOutput("post_reset.wr_ready",     32'(bus.wr_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/char_buf_scheduler.md
Name: char_buf_scheduler

Overview:
Owns the single port of the character-buffer RAM (80x60 cells) and shares it between the VGA scan-out and a host writer. VGA reads always have priority. Queued host writes and a full-screen clear sweep go through only on cycles the scan-out does not use, which are blanking cycles. Sits between the host/UART command path and the character RAM; the VGA driver's char coordinates pass through it.

Parameters:
H_CHARS, 80, columns per screen
V_CHARS, 60, rows per screen
DATA_W, 12, cell width (8b ASCII + 4b colour)
FIFO_DEPTH, 8, host write queue depth (power of 2, >=2)

Ports:
clk_25M  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
vga_rd_en  in  1  VGA driver needs the RAM this cycle (active region, one cycle early)
vga_hchar  in  7  VGA read column
vga_vchar  in  6  VGA read row
wr_valid  in  1  host write request
wr_ready  out  1  queue can accept
wr_hchar  in  7  target column
wr_vchar  in  6  target row
wr_data  in  DATA_W  cell value
clr_req  in  1  single-cycle clear-screen request
clr_data  in  DATA_W  fill value for clear
clr_busy  out  1  clear sweep in progress
err_oob  out  1  one-cycle pulse: accepted write was out of range and dropped
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_hchar  out  7  RAM column address
ram_vchar  out  6  RAM row address
ram_wdata  out  DATA_W  RAM write data

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE, clr_busy=0, err_oob=0. ram_we=0 and ram_wdata=0. wr_ready=1 once the FIFO is empty and the state is not CLEAR-blocked; see wr_ready below.
- Port mux (combinational): vga_rd_en=1 -> ram_en=1, ram_we=0, ram_hchar/ram_vchar = vga coordinates. This holds in every state, so VGA read latency is unchanged (1 cycle). The VGA path is never stalled.
- Free cycle = vga_rd_en=0. Only free cycles may carry a write.
- FIFO push: wr_valid & wr_ready. The range check is done at push: wr_hchar>=H_CHARS or wr_vchar>=V_CHARS -> not stored, err_oob=1 the next cycle.
- wr_ready = !fifo_full. A push and a pop in the same cycle when full are not permitted; wr_ready stays 0 when full.
- States:
  - IDLE: if clr_req -> CLEAR. Otherwise, on a free cycle with the FIFO non-empty -> pop the head and drive ram_en=1, ram_we=1 with its address and data in the same cycle. Stays IDLE.
  - CLEAR: the sweep counter starts at (0,0) and writes clr_data on each free cycle. The column increments first; at H_CHARS-1 it wraps to 0 and the row increments. After cell (H_CHARS-1, V_CHARS-1) is written -> IDLE. clr_busy drops the cycle after the last write. Non-free cycles hold the counter.
- clr_data is latched on clr_req. Later changes to clr_data are ignored during the sweep.
- clr_req in IDLE flushes all FIFO entries present before that cycle. A write pushed in the same cycle as clr_req is retained and executes after the clear.
- Pushes during CLEAR are allowed; they drain in order after the clear.
- clr_req while clr_busy=1: ignored (no restart).
- No free-cycle work pending -> ram_en=0 and ram_we=0 when vga_rd_en=0.
- Latency: a push at cycle N can appear on the RAM at cycle N+1 at the earliest (N+1 must be free and IDLE with no older entries).
- Full clear takes exactly H_CHARS*V_CHARS free cycles.
- Reset mid-sweep or mid-drain: everything is abandoned immediately. There is no partial-write recovery.

Decomposition:
- Shared package char_buf_pkg:
  - H_CHARS/V_CHARS defaults
  - the cell type (char + colour fields)
  - the write-command struct {hchar, vchar, data}
  - the scheduler state enum {IDLE, CLEAR}
- One sub-module: char_cmd_fifo. A synchronous FIFO, FIFO_DEPTH x command struct, with full/empty, push/pop and a flush input. Flush clears pre-existing entries while still accepting a same-cycle push.

Test Plan:
- Reset, then push (5,3,0x041) with vga_rd_en=0 -> next cycle ram_we=1, ram_hchar=5, ram_vchar=3, ram_wdata=0x041. FIFO empty, wr_ready=1.
- Hold vga_rd_en=1 for 20 cycles and push 8 writes -> ram_we=0 throughout, ram address tracks vga coordinates, wr_ready=0 after the 8th push. Drop vga_rd_en -> 8 writes in order on 8 consecutive cycles.
- Push (80,0,x) and (0,60,x) -> no RAM write, err_oob pulses once per write, FIFO stays empty.
- clr_req with clr_data=0x020 and vga_rd_en toggling 1/0 -> exactly 4800 writes covering (0,0)..(79,59) in row-major order with data 0x020. clr_busy=1 for the whole sweep and falls the cycle after the last write.
- 3 queued writes, then clr_req plus a simultaneous push (1,1,0x7AA) -> the 3 entries are never written, the sweep completes, then (1,1,0x7AA) is written. A second clr_req mid-sweep has no effect.
- Assert rst_n=0 mid-sweep at cell (10,2) -> ram_we=0, clr_busy=0 immediately. After release, no further clear writes occur.
